// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, FSM states and redirect-source encoding for the fetch front end.
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC_DEF  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0008;
  localparam logic [31:0] NOP          = 32'h0000_0000;
  typedef enum logic {FETCH, WAIT} state_e;
  // Encoded in ascending priority; SRC_SEQ means no redirect.
  typedef enum logic [2:0] {SRC_SEQ, SRC_BR, SRC_JUMP, SRC_JR, SRC_IRQ, SRC_EXC} src_e;
  function automatic logic is_trap(input src_e s);
    return s == SRC_EXC || s == SRC_IRQ;
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between the load in EX and the sources in ID.
module hazard_detect (
  input  logic       i_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  output logic       o_hazard
);
  assign o_hazard = i_mem_read && |i_ex_rt && (i_ex_rt == i_id_rs || i_ex_rt == i_id_rt);
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: MIPS IF stage - PC register, imem requests, stall/redirect/vectoring into IF/ID.
// DELAY_SLOT_EN: branches/jumps keep the fetched delay-slot instruction; traps still squash.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IRQ_VEC  = IRQ_VEC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        if_id_write,
  output logic        if_flush,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rt,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        irq,
  input  logic        exc,
  output logic        stall_out
);
  state_e      r_state, w_state_nxt;
  src_e        w_src;
  logic [31:0] r_pc, w_pc_nxt, w_target, w_pc4;
  logic        r_active, w_hz, w_stall, w_done, w_redir, w_squash;

  hazard_detect u_hazard (
    .i_mem_read(id_ex_mem_read),
    .i_ex_rt   (id_ex_rt),
    .i_id_rs   (if_id_rs),
    .i_id_rt   (if_id_rt),
    .o_hazard  (w_hz)
  );

  // r_active delays the first request to the first clock after reset release.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_active <= 1'b1;
    end

  always_comb begin
    w_pc4    = r_pc + 32'd4;
    w_stall  = r_active && w_hz && !exc;
    w_done   = r_active && imem_ready && !w_stall;
    w_src    = exc ? SRC_EXC : (irq && w_done) ? SRC_IRQ : jr ? SRC_JR :
               jump ? SRC_JUMP : br_taken ? SRC_BR : SRC_SEQ;
    w_redir  = r_active && !w_stall && w_src != SRC_SEQ;
    w_target = w_src == SRC_EXC ? EXC_VEC : w_src == SRC_IRQ ? IRQ_VEC :
               w_src == SRC_JR ? jr_target : w_src == SRC_JUMP ? jump_target : br_target;
`ifdef DELAY_SLOT_EN
    w_squash = is_trap(w_src);
`else
    w_squash = w_redir;
`endif
    w_pc_nxt    = w_redir ? {w_target[31:2], 2'b00} : w_done ? w_pc4 : r_pc;
    w_state_nxt = (imem_ready || w_redir || (r_state == FETCH && !r_active)) ? FETCH : WAIT;
    imem_req    = r_active;
    imem_addr   = r_pc;
    stall_out   = w_stall;
    if_id_write = r_active && !w_stall;
    if_flush    = w_done && !w_squash;
    instr       = w_done ? imem_rdata : NOP;
    pc_plus4    = w_done ? w_pc4 : 32'h0;
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed plan plus randomized traffic against a cycle-level reference model.
module tb_fetch_ctrl;
  localparam logic [31:0] RST = 32'h8000_0000, IRQV = 32'h8000_0004, EXCV = 32'h8000_0008;
  logic        clk = 0, reset = 0;
  logic        imem_req, imem_ready = 0, if_id_write, if_flush, stall_out;
  logic        id_ex_mem_read = 0, br_taken = 0, jump = 0, jr = 0, irq = 0, exc = 0;
  logic [4:0]  id_ex_rt = 0, if_id_rs = 0, if_id_rt = 0;
  logic [31:0] imem_addr, imem_rdata = 0, pc_plus4, instr;
  logic [31:0] br_target = 0, jump_target = 0, jr_target = 0;
  logic [31:0] m_pc = RST;
  logic        m_act = 0;
  int          n_chk = 0, n_pass = 0;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc_plus4(pc_plus4), .instr(instr),
    .if_id_write(if_id_write), .if_flush(if_flush), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rt(id_ex_rt), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .br_taken(br_taken),
    .br_target(br_target), .jump(jump), .jump_target(jump_target), .jr(jr),
    .jr_target(jr_target), .irq(irq), .exc(exc), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic idle();
    {id_ex_mem_read, br_taken, jump, jr, irq, exc} = '0;
    {id_ex_rt, if_id_rs, if_id_rt} = '0;
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model at the edge.
  task automatic cyc();
    logic hz, st, dn, rd, sq;
    logic [31:0] tg;
    @(negedge clk);
    if (!reset) begin m_act = 0; m_pc = RST; end
    hz = id_ex_mem_read && id_ex_rt != 0 && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
    st = m_act && hz && !exc;
    dn = m_act && imem_ready && !st;
    rd = m_act && !st && (exc || (irq && dn) || jr || jump || br_taken);
    if (exc) tg = EXCV;
    else if (irq && dn) tg = IRQV;
    else if (jr) tg = jr_target;
    else if (jump) tg = jump_target;
    else tg = br_target;
`ifdef DELAY_SLOT_EN
    sq = exc || (irq && dn);
`else
    sq = rd;
`endif
    chk("imem_req", imem_req, m_act);
    chk("imem_addr", imem_addr, m_pc);
    chk("stall_out", stall_out, st);
    chk("if_id_write", if_id_write, m_act && !st);
    chk("if_flush", if_flush, dn && !sq);
    if (dn) begin
      chk("instr", instr, imem_rdata);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    end
    if (!m_act) begin
      chk("instr_rst", instr, 0);
      chk("pc_plus4_rst", pc_plus4, 0);
    end
    @(posedge clk);
    if (reset) begin
      if (!m_act) m_act = 1;
      else if (rd) m_pc = tg & 32'hFFFF_FFFC;
      else if (dn) m_pc = m_pc + 32'd4;
    end
    #1;
    imem_rdata = $urandom;
  endtask

  initial begin
    cyc(); cyc();
    reset = 1; imem_ready = 1;
    cyc(); chk("start_addr", imem_addr, 32'h8000_0000);
    cyc(); chk("seq_addr4", imem_addr, 32'h8000_0004);
    imem_ready = 0;
    repeat (3) cyc();
    chk("wait_hold", imem_addr, 32'h8000_0004);
    imem_ready = 1;
    cyc(); chk("wait_done", imem_addr, 32'h8000_0008);
    id_ex_mem_read = 1; id_ex_rt = 5; if_id_rs = 5;
    cyc(); chk("stall_hold", imem_addr, 32'h8000_0008);
    id_ex_rt = 0;
    cyc(); chk("rt0_nostall", imem_addr, 32'h8000_000C);
    idle(); br_taken = 1; br_target = 32'h8000_0100; jump = 1; jump_target = 32'h8000_0200;
    cyc(); chk("jump_over_br", imem_addr, 32'h8000_0200);
    idle(); exc = 1; irq = 1; id_ex_mem_read = 1; id_ex_rt = 7; if_id_rt = 7;
    cyc(); chk("exc_vec", imem_addr, 32'h8000_0008);
    idle(); jump = 1; jump_target = 32'hFFFF_FFFF;
    cyc(); chk("align", imem_addr, 32'hFFFF_FFFC);
    idle();
    cyc(); chk("wrap", imem_addr, 32'h0);
    imem_ready = 0;
    cyc();
    reset = 0; #2 imem_ready = 1;
    cyc(); imem_ready = 0; cyc(); imem_ready = 1; cyc();
    reset = 1;
    cyc(); chk("post_reset", imem_addr, 32'h8000_0000);
    cyc();
    for (int i = 0; i < 3000; i++) begin
      imem_ready     = $urandom_range(0, 9) < 7;
      id_ex_mem_read = $urandom_range(0, 3) == 0;
      id_ex_rt       = 5'($urandom_range(0, 3));
      if_id_rs       = 5'($urandom_range(0, 3));
      if_id_rt       = 5'($urandom_range(0, 3));
      br_taken       = $urandom_range(0, 9) == 0;
      jump           = $urandom_range(0, 19) == 0;
      jr             = $urandom_range(0, 19) == 0;
      irq            = $urandom_range(0, 9) == 0;
      exc            = $urandom_range(0, 49) == 0;
      br_target = $urandom; jump_target = $urandom; jr_target = $urandom;
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch front end of the 5-stage MIPS pipeline.
- Owns the PC register and issues instruction-memory requests.
- Drives the PC, instruction and control strobes (if_id_write, if_flush) into the IF/ID pipeline register.
- Resolves load-use stalls, taken-branch/jump/jr redirects, interrupt and exception vectoring, and multi-cycle instruction-memory waits.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- IRQ_VEC, 32'h8000_0004, interrupt entry address.
- EXC_VEC, 32'h8000_0008, exception entry address.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, held until accepted
- imem_addr  out  32  fetch address (current PC)
- imem_ready  in  1  imem_rdata valid / request accepted this cycle
- imem_rdata  in  32  fetched instruction
- pc_plus4  out  32  PC+4 of the fetched instruction, to IF/ID PC input
- instr  out  32  fetched instruction, to IF/ID instruction input
- if_id_write  out  1  1 = IF/ID latches this cycle; 0 = IF/ID holds
- if_flush  out  1  0 = IF/ID latches NOP (32'b0); 1 = IF/ID latches instr
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rt  in  5  load destination register
- if_id_rs  in  5  rs of instruction in ID
- if_id_rt  in  5  rt of instruction in ID
- br_taken  in  1  branch resolved taken in ID
- br_target  in  32  branch target
- jump  in  1  j/jal in ID
- jump_target  in  32  jump target
- jr  in  1  jr/jalr in ID
- jr_target  in  32  register target
- irq  in  1  level interrupt request, sampled when PC advances
- exc  in  1  exception pulse (illegal opcode/overflow)
- stall_out  out  1  load-use hazard indication, zeroes ID/EX control

Behaviour:
- Reset (async, active-low):
  - PC=RESET_PC, state=FETCH, imem_req=0.
  - pc_plus4=0, instr=0, if_id_write=0, if_flush=0, stall_out=0.
  - First request issues on the first clock after reset deasserts.
  - Reset mid-WAIT abandons the outstanding request; a late imem_ready is ignored.
- States:
  - FETCH: imem_req=1, imem_addr=PC.
  - WAIT: request outstanding, no imem_ready yet.
  - Transitions: FETCH→WAIT if imem_ready=0; WAIT→FETCH on imem_ready.
- Fetch cycle: when imem_ready=1 and no stall, the instruction is handed to IF/ID in the same cycle:
  - instr=imem_rdata, pc_plus4=PC+4, if_id_write=1, if_flush=1.
  - PC<=next PC.
- No completed fetch (WAIT, or imem_ready=0): if_id_write=1, if_flush=0, so a bubble enters ID; PC holds.
- Load-use hazard (combinational): id_ex_mem_read && id_ex_rt!=0 && (id_ex_rt==if_id_rs || id_ex_rt==if_id_rt).
  - stall_out=1, if_id_write=0, PC holds.
  - An imem_ready in this cycle is discarded and the same PC is re-requested.
- Next-PC priority (highest first):
  - exc → EXC_VEC
  - irq (only when a fetch completes) → IRQ_VEC
  - jr → jr_target
  - jump → jump_target
  - br_taken → br_target
  - else PC+4
- Redirect (exc, irq, jr, jump, br_taken) squashes the instruction fetched this cycle: if_flush=0, if_id_write=1.
- Simultaneous events:
  - exc overrides a load-use stall: redirect happens, stall_out=0.
  - Any redirect overrides WAIT: the outstanding response is dropped, then a fetch of the new PC starts next cycle.
- Arithmetic: PC+4 is 32-bit, wraps 32'hFFFF_FFFC→0. PC[1:0] is forced to 00 on every load.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined: br_taken, jump and jr do not squash the fetched instruction (if_flush=1), matching MIPS delay-slot semantics; exc/irq still squash.
- Undefined: every redirect squashes, as described above.

Decomposition:
- Package fetch_pkg: RESET_PC/IRQ_VEC/EXC_VEC defaults, NOP constant 32'h0, state enum {FETCH, WAIT}, redirect-source priority encoding.
- Sub-module hazard_detect: purely combinational load-use comparator producing stall_out; instantiated once.

Test Plan:
- Reset release, imem_ready tied 1 → addresses 8000_0000, _0004, _0008 on consecutive cycles; if_flush=1, pc_plus4=addr+4.
- imem_ready low 3 cycles at 8000_0004 → imem_addr holds 8000_0004; 3 bubbles (if_id_write=1, if_flush=0); then the instruction is passed.
- id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 → stall_out=1, if_id_write=0, PC holds 1 cycle; with id_ex_rt=0, no stall.
- br_taken=1, br_target=8000_0100 together with jump=1, jump_target=8000_0200 → next addr 8000_0200, squash (if_flush=0); with DELAY_SLOT_EN, if_flush=1.
- exc=1 together with irq=1 and a load-use hazard → next addr 8000_0008, stall_out=0, squash.
- reset asserted while in WAIT, imem_ready pulses during reset → outputs held at reset values; first fetch after release is 8000_0000.
